// File: rtl/adc_sample_decimator.sv
// Boxcar decimator for ADC samples: averages blocks of 2^LOG2_DEC captured
// samples and streams the averages out through a small valid/ready FIFO.
module adc_sample_decimator #(
    parameter int BYTE_W    = 8,
    parameter int LOG2_DEC  = 3,
    parameter int FIFO_LOG2 = 2
) (
    input  logic              sys_clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [BYTE_W-1:0] adc_data,
    input  logic              adc_rx_done,
    output logic [BYTE_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              ovf,
    input  logic              ovf_clr,
    output logic [7:0]        drop_ct
);

    localparam int ACC_W = BYTE_W + LOG2_DEC;
    localparam int DEPTH = 1 << FIFO_LOG2;

    logic                 rx_q;
    logic [ACC_W-1:0]     acc;
    logic [ACC_W-1:0]     sum;
    logic [LOG2_DEC-1:0]  cnt;
    logic                 accept;
    logic                 block_done;
    logic                 push;
    logic                 pop;
    logic                 wr_en;
    logic                 drop;
    logic                 empty;
    logic                 full;
    logic [FIFO_LOG2:0]   wr_ptr;
    logic [FIFO_LOG2:0]   rd_ptr;
    logic [BYTE_W-1:0]    result;
    logic [BYTE_W-1:0]    mem [DEPTH];

    // Rising-edge detect on the done strobe; a held-high strobe counts once.
    assign accept     = adc_rx_done & ~rx_q & en;
    assign block_done = &cnt;
    assign sum        = acc + ACC_W'(adc_data);
    assign result     = sum[ACC_W-1:LOG2_DEC];
    assign push       = accept & block_done;

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[FIFO_LOG2] != rd_ptr[FIFO_LOG2]) &&
                       (wr_ptr[FIFO_LOG2-1:0] == rd_ptr[FIFO_LOG2-1:0]);
    assign out_valid = ~empty;
    assign pop       = out_valid & out_ready;
    // A pop in the same cycle frees the slot the push needs.
    assign wr_en     = push & (~full | pop);
    assign drop      = push & full & ~pop;
    assign out_data  = mem[rd_ptr[FIFO_LOG2-1:0]];

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_q <= 1'b0;
        end else begin
            rx_q <= adc_rx_done;
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            cnt <= '0;
        end else if (!en) begin
            acc <= '0;
            cnt <= '0;
        end else if (accept) begin
            if (block_done) begin
                acc <= '0;
                cnt <= '0;
            end else begin
                acc <= sum;
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Storage is deliberately unreset; out_valid gates its contents.
    always_ff @(posedge sys_clk) begin
        if (wr_en) begin
            mem[wr_ptr[FIFO_LOG2-1:0]] <= result;
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // A drop in the same cycle as a clear keeps the flag set.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf     <= 1'b0;
            drop_ct <= 8'd0;
        end else begin
            if (drop) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
            if (drop && drop_ct != 8'hFF) begin
                drop_ct <= drop_ct + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_adc_sample_decimator.sv
// Self-checking bench for adc_sample_decimator: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_adc_sample_decimator;

    localparam int DEC   = 8;
    localparam int DEPTH = 4;

    logic       sys_clk;
    logic       rst_n;
    logic       en;
    logic [7:0] adc_data;
    logic       adc_rx_done;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       ovf;
    logic       ovf_clr;
    logic [7:0] drop_ct;

    int n_vec;
    int n_err;

    // Reference model state
    int  blk_q[$];
    int  fifo_q[$];
    bit  m_ovf;
    int  m_drop;
    bit  m_prev_done;

    adc_sample_decimator dut (
        .sys_clk    (sys_clk),
        .rst_n      (rst_n),
        .en         (en),
        .adc_data   (adc_data),
        .adc_rx_done(adc_rx_done),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ovf        (ovf),
        .ovf_clr    (ovf_clr),
        .drop_ct    (drop_ct)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        blk_q.delete();
        fifo_q.delete();
        m_ovf       = 1'b0;
        m_drop      = 0;
        m_prev_done = 1'b0;
    endtask

    // Compare outputs against the model, advance the model by one cycle with
    // the current inputs, then move to just after the next rising edge.
    task automatic tick();
        bit acc_now;
        bit push_req;
        bit dropped;
        int sum;
        int res;
        #2;
        check("out_valid", out_valid, fifo_q.size() != 0);
        if (fifo_q.size() != 0) check("out_data", out_data, fifo_q[0]);
        check("ovf", ovf, m_ovf);
        check("drop_ct", drop_ct, m_drop);

        acc_now  = adc_rx_done && !m_prev_done && en;
        push_req = 1'b0;
        dropped  = 1'b0;
        res      = 0;
        if (!en) begin
            blk_q.delete();
        end else if (acc_now) begin
            blk_q.push_back(int'(adc_data));
            if (blk_q.size() == DEC) begin
                sum = 0;
                foreach (blk_q[i]) sum += blk_q[i];
                res = sum / DEC;
                blk_q.delete();
                push_req = 1'b1;
            end
        end
        if (fifo_q.size() != 0 && out_ready) void'(fifo_q.pop_front());
        if (push_req) begin
            if (fifo_q.size() < DEPTH) begin
                fifo_q.push_back(res);
            end else begin
                dropped = 1'b1;
                m_ovf   = 1'b1;
                if (m_drop < 255) m_drop++;
            end
        end
        if (!dropped && ovf_clr) m_ovf = 1'b0;
        m_prev_done = adc_rx_done;

        @(posedge sys_clk);
        #1;
    endtask

    task automatic send_sample(input logic [7:0] d, input int hold, input int gap);
        adc_data    = d;
        adc_rx_done = 1'b1;
        repeat (hold) tick();
        adc_rx_done = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic send_block(input logic [7:0] d);
        repeat (DEC) send_sample(d, 1, 1);
    endtask

    // Asynchronous reset: outputs must clear without waiting for a clock edge.
    task automatic do_reset();
        adc_rx_done = 1'b0;
        rst_n       = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_ovf", ovf, 1'b0);
        check("rst_drop_ct", drop_ct, 8'd0);
        model_clear();
        @(posedge sys_clk);
        @(posedge sys_clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        n_vec       = 0;
        n_err       = 0;
        rst_n       = 1'b1;
        en          = 1'b0;
        adc_data    = 8'd0;
        adc_rx_done = 1'b0;
        out_ready   = 1'b0;
        ovf_clr     = 1'b0;
        model_clear();
        #1;
        do_reset();
        repeat (2) tick();

        $display("[TB] basic average");
        en        = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) send_sample(8'(8'h10 + i), 1, 1);
        send_sample(8'h17, 1, 0);
        #2;
        check("basic_valid", out_valid, 1'b1);
        check("basic_data", out_data, 8'h13);
        tick();
        adc_rx_done = 1'b0;
        repeat (3) tick();

        $display("[TB] held strobe");
        send_sample(8'hFF, 20, 1);
        repeat (7) send_sample(8'hFF, 1, 1);
        repeat (3) tick();

        $display("[TB] overflow");
        out_ready = 1'b0;
        repeat (5) send_block(8'h40);
        tick();
        check("ovf_set", ovf, 1'b1);
        check("ovf_drop_ct", drop_ct, 8'd1);
        out_ready = 1'b1;
        repeat (6) tick();

        $display("[TB] full with simultaneous push and pop");
        ovf_clr = 1'b1;
        tick();
        ovf_clr   = 1'b0;
        out_ready = 1'b0;
        repeat (4) send_block(8'h50);
        for (int i = 0; i < DEC - 1; i++) send_sample(8'h60, 1, 1);
        out_ready = 1'b1;
        send_sample(8'h60, 1, 0);
        out_ready = 1'b0;
        tick();
        check("simul_ovf", ovf, 1'b0);
        check("simul_drop_ct", drop_ct, 8'd1);

        $display("[TB] clear coincident with drop");
        for (int i = 0; i < DEC - 1; i++) send_sample(8'h70, 1, 1);
        ovf_clr = 1'b1;
        send_sample(8'h70, 1, 0);
        ovf_clr = 1'b0;
        tick();
        check("clr_vs_drop_ovf", ovf, 1'b1);
        check("clr_vs_drop_ct", drop_ct, 8'd2);
        out_ready = 1'b1;
        repeat (6) tick();

        $display("[TB] en drop mid-block");
        repeat (5) send_sample(8'h80, 1, 1);
        en = 1'b0;
        tick();
        en = 1'b1;
        send_block(8'h20);
        repeat (3) tick();

        $display("[TB] reset mid-operation");
        out_ready = 1'b0;
        repeat (3) send_block(8'h33);
        repeat (4) send_sample(8'h99, 1, 1);
        do_reset();
        out_ready = 1'b1;
        send_block(8'h01);
        repeat (3) tick();

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            en        = ($urandom_range(0, 19) != 0);
            out_ready = 1'($urandom_range(0, 1));
            ovf_clr   = ($urandom_range(0, 15) == 0);
            send_sample(8'($urandom_range(0, 255)), $urandom_range(1, 3), $urandom_range(0, 2));
        end
        en        = 1'b1;
        ovf_clr   = 1'b0;
        out_ready = 1'b1;
        repeat (8) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/adc_sample_decimator.md
# adc_sample_decimator

Downstream consumer of the ADC serial interface's parallel output. Captures each completed 8-bit sample on the rising edge of the interface's done strobe, boxcar-averages blocks of 2^LOG2_DEC samples, and queues each block average in a small FIFO. Results leave through a valid/ready stream for the rest of the sys_clk domain: packetizer, UART bridge or DSP.

## Interface
- BYTE_W, default 8: sample and output width.
- LOG2_DEC, default 3: log2 of the decimation ratio. Legal range 1..6.
- FIFO_LOG2, default 2: log2 of FIFO depth (default depth 4). Must be ≥1.
- sys_clk  in  1: single clock; all logic is on posedge.
- rst_n  in  1: asynchronous, active-low reset.
- en  in  1: enables accumulation. Low discards any partial block.
- adc_data  in  BYTE_W: sample from the ADC interface. Stable while adc_rx_done is high.
- adc_rx_done  in  1: sample-complete strobe. May stay high for many cycles.
- out_data  out  BYTE_W: FIFO head; valid only while out_valid is high.
- out_valid  out  1: FIFO not empty.
- out_ready  in  1: consumer accepts out_data this cycle.
- ovf  out  1: sticky flag; a block result was dropped because the FIFO was full.
- ovf_clr  in  1: synchronous clear of ovf.
- drop_ct  out  8: saturating count of dropped results.

## Operation
- Capture: register rx_q <= adc_rx_done. accept = adc_rx_done & ~rx_q & en. A held-high strobe counts once.
- rx_q tracks adc_rx_done regardless of en. A strobe already high when en rises is not accepted.
- Accumulator acc, width BYTE_W+LOG2_DEC. Sample counter cnt, width LOG2_DEC.
- On accept with cnt != 2^LOG2_DEC−1: acc <= acc + adc_data; cnt <= cnt+1.
- On accept with cnt == 2^LOG2_DEC−1: result = (acc + adc_data) >> LOG2_DEC, truncated with no rounding. Push result; acc <= 0; cnt <= 0.
- The sum cannot overflow: the maximum is 2^LOG2_DEC·(2^BYTE_W−1).
- When en is low: acc <= 0, cnt <= 0, no accepts. The FIFO keeps draining, and ovf and drop_ct hold.
- FIFO: circular buffer with wr_ptr and rd_ptr of FIFO_LOG2+1 bits each.
  - empty = pointers equal.
  - full = MSBs differ and low bits equal.
  - Pointers wrap naturally.
- pop = out_valid & out_ready. The push is allowed if ~full, or if full and pop occurs in the same cycle.
- When both push and pop are allowed in the same cycle, both occur and occupancy is unchanged.
- Dropped push (full and no pop): the result is discarded, ovf <= 1, and drop_ct increments with saturation at 255.
- ovf_clr clears ovf. If a drop happens in the same cycle as ovf_clr, set wins and ovf stays 1. drop_ct is cleared only by reset.
- out_data = mem[rd_ptr] (combinational read of registered storage).

## Timing
- Reset (async assert, sync release use): acc=0, cnt=0, rx_q=0, pointers=0, out_valid=0, out_data=don't-care, ovf=0, drop_ct=0.
- Accept is evaluated in the cycle adc_rx_done is first seen high. acc, cnt and the FIFO write update at that edge.
- Latency: with an empty FIFO, out_valid rises 1 cycle after the cycle containing the final sample's accept.
- Throughput: one push and one pop per cycle maximum. The ADC delivers a sample every ≥16 ser_clk periods, far below this.
- out_valid/out_data hold until popped. The consumer may hold out_ready high continuously.
- Mid-operation reset: all state is lost immediately, the FIFO empties, and out_valid drops asynchronously.
- Accept on the same cycle en falls: not accepted. en is sampled in the same cycle as the strobe.

## Test plan
- Basic average: en=1, out_ready=1, eight strobes with data 0x10..0x17 → one output 0x13 (156>>3), out_valid high exactly 1 cycle after the 8th accept; cnt back to 0.
- Held strobe: adc_rx_done held high 20 cycles with data 0xFF, then 7 more single pulses of 0xFF → exactly one output 0xFF. Holding does not produce extra counts.
- Overflow: out_ready=0, 5 full blocks of 0x40 → 4 entries, out_valid=1, ovf=1, drop_ct=1. Then drain with out_ready=1 → four 0x40 outputs, then out_valid=0.
- Full with simultaneous push/pop: FIFO full, 5th block completes in the cycle out_ready=1 → no drop, ovf=0, occupancy stays 4, and the new value is last out. ovf_clr coincident with a drop → ovf=1.
- en drop mid-block: 5 samples of 0x80, en low 1 cycle, en high, 8 samples of 0x20 → single output 0x20. The partial block is discarded.
- Reset mid-operation: 3 entries queued, cnt=4, assert rst_n=0 → out_valid=0, ovf=0, drop_ct=0 immediately. After release, 8 samples of 0x01 → output 0x01.
